// File: rtl/keypad_matrix_scanner.sv
// 4x3 matrix keypad scanner: column drive, row sampling, per-key debounce,
// debounced level outputs and a one-cycle new-press strobe with key code.
module keypad_matrix_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] KEY_ROW,
  output logic [2:0] KEY_COL,
  output logic [9:0] KEY,
  output logic       KEY_STAR,
  output logic       KEY_HASH,
  output logic       KEY_VALID,
  output logic [3:0] KEY_CODE
);

  typedef enum logic [1:0] {
    IDLE,
    COL0,
    COL1,
    COL2
  } state_e;

  localparam logic [15:0] LAST  = 16'(SCAN_CYCLES - 1);
  localparam logic [3:0]  DEB_N = 4'(DEBOUNCE_FRAMES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  meta_q, sync_q;
  logic [11:0] raw_q, raw_d;
  logic        eval_q, eval_d;
  logic        upd_q, upd_d;
  logic [11:0] deb_q, deb_d;
  logic [3:0]  dcnt_q [12];
  logic [3:0]  dcnt_d [12];
  logic [11:0] lvl_q, lvl_d;
  logic [11:0] newp;
  logic        valid_q, valid_d;
  logic [3:0]  code_q, code_d;
  logic [1:0]  col;
  logic        last;

  // Key code at (row, col); raw/debounced vectors are indexed by code
  function automatic logic [3:0] code_of(input int r, input int c);
    case (r * 3 + c)
      0:       return 4'd1;
      1:       return 4'd2;
      2:       return 4'd3;
      3:       return 4'd4;
      4:       return 4'd5;
      5:       return 4'd6;
      6:       return 4'd7;
      7:       return 4'd8;
      8:       return 4'd9;
      9:       return 4'd10;
      10:      return 4'd0;
      default: return 4'd11;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    eval_d  = 1'b0;
    col     = 2'd0;
    KEY_COL = 3'b111;
    last    = (cnt_q == LAST);
    unique case (state_q)
      COL0: begin
        col     = 2'd0;
        KEY_COL = 3'b110;
      end
      COL1: begin
        col     = 2'd1;
        KEY_COL = 3'b101;
      end
      COL2: begin
        col     = 2'd2;
        KEY_COL = 3'b011;
      end
      default: ;
    endcase
    if (state_q == IDLE) begin
      state_d = COL0;
      cnt_d   = '0;
    end else if (last) begin
      cnt_d = '0;
      for (int r = 0; r < 4; r++) begin
        raw_d[code_of(r, int'(col))] = ~sync_q[r];
      end
      unique case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        default: begin
          state_d = COL0;
          eval_d  = 1'b1;
        end
      endcase
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (eval_q) begin
      for (int k = 0; k < 12; k++) begin
        if (raw_q[k] == deb_q[k]) begin
          dcnt_d[k] = '0;
        end else if (dcnt_q[k] + 4'd1 == DEB_N) begin
          deb_d[k]  = raw_q[k];
          dcnt_d[k] = '0;
        end else begin
          dcnt_d[k] = dcnt_q[k] + 4'd1;
        end
      end
    end
  end

  // lvl_q still holds the previous debounced state while upd_q is high
  always_comb begin
    lvl_d   = lvl_q;
    valid_d = 1'b0;
    code_d  = code_q;
    upd_d   = eval_q;
    newp    = deb_q & ~lvl_q;
    if (upd_q) begin
      lvl_d   = deb_q;
      valid_d = |newp;
      for (int k = 11; k >= 0; k--) begin
        if (newp[k]) code_d = 4'(k);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      meta_q  <= 4'hF;
      sync_q  <= 4'hF;
      raw_q   <= '0;
      eval_q  <= 1'b0;
      upd_q   <= 1'b0;
      deb_q   <= '0;
      for (int k = 0; k < 12; k++) dcnt_q[k] <= '0;
      lvl_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      meta_q  <= KEY_ROW;
      sync_q  <= meta_q;
      raw_q   <= raw_d;
      eval_q  <= eval_d;
      upd_q   <= upd_d;
      deb_q   <= deb_d;
      for (int k = 0; k < 12; k++) dcnt_q[k] <= dcnt_d[k];
      lvl_q   <= lvl_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign KEY       = lvl_q[9:0];
  assign KEY_STAR  = lvl_q[10];
  assign KEY_HASH  = lvl_q[11];
  assign KEY_VALID = valid_q;
  assign KEY_CODE  = code_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural 4x3 keypad
// (SCAN_CYCLES=8, DEBOUNCE_FRAMES=2: one frame = 24 cycles).
module tb_keypad_matrix_scanner;

  localparam int MAP [4][3] = '{
    '{1, 2, 3},
    '{4, 5, 6},
    '{7, 8, 9},
    '{10, 0, 11}
  };

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [3:0] KEY_ROW;
  logic [2:0] KEY_COL;
  logic [9:0] KEY;
  logic       KEY_STAR;
  logic       KEY_HASH;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;

  logic [11:0] held;
  int          cyc;
  int          vcnt;
  int          checks;
  int          failures;

  keypad_matrix_scanner #(
    .SCAN_CYCLES    (8),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .KEY_ROW  (KEY_ROW),
    .KEY_COL  (KEY_COL),
    .KEY      (KEY),
    .KEY_STAR (KEY_STAR),
    .KEY_HASH (KEY_HASH),
    .KEY_VALID(KEY_VALID),
    .KEY_CODE (KEY_CODE)
  );

  always #5 CLK = ~CLK;

  // Passive keypad: a held key pulls its row low while its column is driven
  always_comb begin
    KEY_ROW = 4'hF;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!KEY_COL[c] && held[MAP[r][c]]) KEY_ROW[r] = 1'b0;
      end
    end
  end

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (KEY_VALID) vcnt = vcnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    vcnt     = 0;
    held     = '0;
    RESETN   = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_col", 32'(KEY_COL), 'h7);
    chk("rst_key", 32'(KEY), 0);
    chk("rst_valid", 32'(KEY_VALID), 0);
    chk("rst_code", 32'(KEY_CODE), 0);
    RESETN = 1'b1;

    // 1: idle scanning
    goto(1);  chk("col_c1", 32'(KEY_COL), 'h6);
    goto(8);  chk("col_c8", 32'(KEY_COL), 'h6);
    goto(9);  chk("col_c9", 32'(KEY_COL), 'h5);
    goto(16); chk("col_c16", 32'(KEY_COL), 'h5);
    goto(17); chk("col_c17", 32'(KEY_COL), 'h3);
    goto(24); chk("col_c24", 32'(KEY_COL), 'h3);
    goto(25); chk("col_c25", 32'(KEY_COL), 'h6);
    goto(51);
    chk("idle_key", 32'(KEY), 0);
    chk("idle_vcnt", vcnt, 0);

    // 2: hold '5' from frame 3 -> levels after frame 4
    held[5] = 1'b1;
    goto(98); chk("k5_early", 32'(KEY), 0);
    goto(99);
    chk("k5_key", 32'(KEY), 'h020);
    chk("k5_valid", 32'(KEY_VALID), 1);
    chk("k5_code", 32'(KEY_CODE), 5);
    chk("k5_starhash", 32'({KEY_STAR, KEY_HASH}), 0);
    goto(100);
    chk("k5_pulse_end", 32'(KEY_VALID), 0);
    chk("k5_vcnt", vcnt, 1);

    // 3: '#' bounces frames 5..8, steady from frame 9
    held[11] = 1'b1;
    goto(121); held[11] = 1'b0;
    goto(145); held[11] = 1'b1;
    goto(169); held[11] = 1'b0;
    chk("hash_bounce_a", 32'(KEY_HASH), 0);
    goto(193); held[11] = 1'b1;
    goto(219); chk("hash_bounce_b", 32'(KEY_HASH), 0);
    goto(242);
    chk("hash_early", 32'(KEY_HASH), 0);
    chk("hash_vcnt_quiet", vcnt, 1);
    goto(243);
    chk("hash_level", 32'(KEY_HASH), 1);
    chk("hash_valid", 32'(KEY_VALID), 1);
    chk("hash_code", 32'(KEY_CODE), 11);
    goto(244);
    chk("hash_vcnt", vcnt, 2);
    chk("hash_key", 32'(KEY), 'h020);

    // 4: '7' and '0' together in frame 11
    held[7] = 1'b1;
    held[0] = 1'b1;
    goto(290); chk("k70_early", 32'(KEY), 'h020);
    goto(291);
    chk("k70_key", 32'(KEY), 'h0A1);
    chk("k70_valid", 32'(KEY_VALID), 1);
    chk("k70_code", 32'(KEY_CODE), 0);
    goto(292);
    chk("k70_vcnt", vcnt, 3);

    // 5: release '5' in frame 13, re-press in frame 15
    held[5] = 1'b0;
    goto(338); chk("rel_early", 32'(KEY), 'h0A1);
    goto(339);
    chk("rel_key", 32'(KEY), 'h081);
    chk("rel_valid", 32'(KEY_VALID), 0);
    goto(340);
    chk("rel_vcnt", vcnt, 3);
    held[5] = 1'b1;
    goto(386); chk("rep_early", 32'(KEY), 'h081);
    goto(387);
    chk("rep_key", 32'(KEY), 'h0A1);
    chk("rep_valid", 32'(KEY_VALID), 1);
    chk("rep_code", 32'(KEY_CODE), 5);
    goto(388);
    chk("rep_vcnt", vcnt, 4);

    // 6: '3' pressed, then reset in the middle of COL1
    held[3] = 1'b1;
    goto(435);
    chk("k3_key", 32'(KEY), 'h0A9);
    chk("k3_code", 32'(KEY_CODE), 3);
    goto(444);
    chk("mid_col1", 32'(KEY_COL), 'h5);
    RESETN = 1'b0;
    #1;
    chk("arst_col", 32'(KEY_COL), 'h7);
    chk("arst_key", 32'(KEY), 0);
    chk("arst_hash", 32'(KEY_HASH), 0);
    chk("arst_valid", 32'(KEY_VALID), 0);
    repeat (2) @(negedge CLK);
    vcnt   = 0;
    RESETN = 1'b1;
    goto(1);  chk("rs_col_c1", 32'(KEY_COL), 'h6);
    goto(9);  chk("rs_col_c9", 32'(KEY_COL), 'h5);
    goto(50); chk("rs_early", 32'(KEY), 0);
    goto(51);
    chk("rs_key", 32'(KEY), 'h0A9);
    chk("rs_hash", 32'(KEY_HASH), 1);
    chk("rs_valid", 32'(KEY_VALID), 1);
    chk("rs_code", 32'(KEY_CODE), 0);
    goto(52);
    chk("rs_vcnt", vcnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Drives and reads the board's 4x3 matrix keypad and produces the debounced key levels that the game top level consumes: KEY[9:0] for digits and KEY_HASH for '#'.
- Also produces a one-cycle new-press strobe with an encoded key code.
- This is the keypad-side producer for the top level's keypad inputs.
- Runs on the 1 MHz system clock.

Parameters:
- SCAN_CYCLES, 1000, clock cycles each column is driven (1 ms at 1 MHz); legal range 4..65535.
- DEBOUNCE_FRAMES, 4, consecutive frames a key's raw state must differ from its debounced state before the debounced state flips; legal range 1..15.

Ports:
- CLK  in  1  system clock, 1 MHz.
- RESETN  in  1  asynchronous, active-low reset.
- KEY_ROW  in  4  row returns; active-low, externally pulled up.
- KEY_COL  out  3  column drives; active-low, one-hot-low while scanning.
- KEY  out  10  debounced level per digit 0..9; 1 = held.
- KEY_STAR  out  1  debounced level of '*'.
- KEY_HASH  out  1  debounced level of '#'.
- KEY_VALID  out  1  one-cycle pulse when at least one key newly became pressed.
- KEY_CODE  out  4  code of the newly pressed key; valid while KEY_VALID=1, held otherwise.

Behaviour:
- Matrix map (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Codes: digits 0..9 = their value; '*' = 10; '#' = 11.
- Reset (RESETN low, asynchronous):
  - KEY_COL = 3'b111.
  - KEY, KEY_STAR, KEY_HASH, KEY_VALID = 0; KEY_CODE = 0.
  - Cycle counter, column index, raw frame, debounce counters and debounced states all cleared.
  - Reset asserted mid-frame discards the partial frame.
- Input sync: KEY_ROW passes through a 2-flop synchronizer before use.
- Scan FSM, states COL0 -> COL1 -> COL2 -> COL0:
  - First rising edge after reset release enters COL0 with KEY_COL = 3'b110.
  - COL1 drives 3'b101; COL2 drives 3'b011.
  - Each state lasts exactly SCAN_CYCLES cycles.
- Sampling: on the last cycle of each column state (counter = SCAN_CYCLES-1), the synchronized rows are inverted (1 = pressed) and stored into that column's 4 bits of a 12-bit raw frame.
- Frame end is the sample in COL2. On the following cycle the debounce stage evaluates all 12 keys in parallel.
- Debounce, per key:
  - If raw == debounced, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_FRAMES, the debounced state takes the raw value and the counter clears.
  - Symmetric for press and release.
  - Counter width is 4 bits and saturation cannot occur.
- Level outputs are registered copies of the debounced states. They change only in the cycle after the debounce evaluation.
- New-press detect: new = debounced_next & ~debounced_prev, evaluated once per frame.
  - If any bit of new is set: KEY_VALID = 1 for exactly one cycle, aligned with the level outputs updating.
  - KEY_CODE = lowest code among the new presses.
  - Simultaneous new presses in one frame produce one pulse only; the higher codes are not reported later.
  - Releases never pulse KEY_VALID.
- Latency: a key held steadily from the start of a frame asserts its level output DEBOUNCE_FRAMES*3*SCAN_CYCLES + 2 cycles after that frame starts (12.002 ms at defaults).
- Ghosting: three or more simultaneous presses may produce phantom keys. There is no suppression; this is accepted behaviour.
- Rows are never driven by this block.

Test Plan:
1. Reset hold, then release with SCAN_CYCLES=8, DEBOUNCE_FRAMES=2 and rows all 1 -> KEY_COL cycles 110/101/011 every 8 cycles starting at the first edge after release; all outputs remain 0.
2. Hold '5' (row1 low whenever col1 is driven) -> KEY[5]=1 in the cycle after the 2nd frame-end evaluation; KEY_VALID high exactly 1 cycle with KEY_CODE=5; no other bits set.
3. '#' bounces (row3 toggling every other frame during col2), then holds steady -> KEY_HASH stays 0 through the bounce and asserts only after 2 consecutive pressed frames; one pulse with KEY_CODE=11.
4. '7' and '0' become stable in the same frame -> KEY[7]=KEY[0]=1 together; a single KEY_VALID pulse with KEY_CODE=0.
5. Release a held '5' -> KEY[5] drops after 2 released frames with no KEY_VALID pulse; a re-press afterwards pulses again with KEY_CODE=5.
6. Assert RESETN low in the middle of COL1 while '3' is debounced pressed -> KEY_COL=111 and KEY=0 immediately (asynchronously); after release, scanning restarts at COL0 and '3' reasserts after 2 frames.
